// File: rtl/ifq_pkg.sv
// Shared types and constants for the IF->ID fetch queue.
package ifq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] IFQ_BUBBLE_INST   = 32'd0;
    localparam int unsigned IFQ_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/ifq_storage.sv
// Register-array storage for the fetch queue: one write port, one asynchronous read port.
module ifq_storage
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Circular FIFO decoupling instruction fetch from ID, flushed on a taken branch.
// Optional macro IFQ_FLUSH_STATS_EN adds a saturating count of discarded fetches.
module if_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH  = IFQ_DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_pc,
    input  logic [ADDR_W-1:0]            in_inst,
    input  logic                         branch_taken,
    input  logic                         hazard,
    output logic                         out_valid,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [ADDR_W-1:0]            out_inst,
`ifdef IFQ_FLUSH_STATS_EN
    output logic [15:0]                  flush_drop_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    fetch_entry_t     wdata;
    fetch_entry_t     rdata;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~branch_taken;
    assign pop       = out_valid & ~hazard & ~branch_taken;

    assign wdata.pc   = 32'(in_pc);
    assign wdata.inst = 32'(in_inst);

    ifq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Empty queue presents a bubble to ID.
    assign out_pc   = out_valid ? ADDR_W'(rdata.pc)   : '0;
    assign out_inst = out_valid ? ADDR_W'(rdata.inst) : ADDR_W'(IFQ_BUBBLE_INST);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef IFQ_FLUSH_STATS_EN
    logic [16:0] drop_sum;

    // Discarded work per flush: buffered entries plus the fetch presented that cycle.
    assign drop_sum = 17'(flush_drop_cnt) + 17'(count) + 17'(in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_drop_cnt <= '0;
        end else if (branch_taken) begin
            flush_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule
